// File: rtl/alu_result_decoder.sv
// alu_result_decoder
//   Decodes packed ALU results (add/sub/mul/div) into write-back entries
//   (low byte, high byte, two-byte strobe, Z/N flags, opcode). Entries are
//   buffered in a DEPTH-entry FIFO with valid/ready on both sides.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake; in_ready = (count < DEPTH)
//   op[1:0], result[15:0] opcode and packed result, decoded at push
//   out_valid/out_ready  consumer handshake; out_valid = (count != 0)
//   wb_lo, wb_hi, wb_two write-back bytes and two-byte strobe (head entry)
//   flag_z, flag_n, op_out flags and opcode of head entry
//
// Optional feature (macro ALU_RESULT_DECODER_STATS_EN)
//   cnt_add, cnt_sub, cnt_mul, cnt_div: 16-bit wrapping per-op push counters.
module alu_result_decoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  wb_lo,
  output logic [7:0]  wb_hi,
  output logic        wb_two,
  output logic        flag_z,
  output logic        flag_n,
  output logic [1:0]  op_out
`ifdef ALU_RESULT_DECODER_STATS_EN
  ,
  output logic [15:0] cnt_add,
  output logic [15:0] cnt_sub,
  output logic [15:0] cnt_mul,
  output logic [15:0] cnt_div
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       two;
    logic       z;
    logic       n;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;
  entry_t          w_dec, w_head;
  logic            w_push, w_pop;

  // Flow control depends only on the registered count.
  assign in_ready  = (r_count < CNT_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Decode at push so the stored entry is already in write-back form.
  always_comb begin
    w_dec    = '0;
    w_dec.op = op;
    case (op)
      2'b10: begin
        w_dec.lo  = result[7:0];
        w_dec.hi  = result[15:8];
        w_dec.two = 1'b1;
        w_dec.z   = (result == 16'h0000);
        w_dec.n   = result[15];
      end
      2'b11: begin
        // Quotient lives in the upper byte, remainder in the lower.
        w_dec.lo  = result[15:8];
        w_dec.hi  = result[7:0];
        w_dec.two = 1'b1;
        w_dec.z   = (result[15:8] == 8'h00);
        w_dec.n   = result[15];
      end
      default: begin
        // add/sub: only the low byte is meaningful, upper result bits ignored.
        w_dec.lo  = result[7:0];
        w_dec.hi  = {8{result[7]}};
        w_dec.two = 1'b0;
        w_dec.z   = (result[7:0] == 8'h00);
        w_dec.n   = result[7];
      end
    endcase
  end

  // Storage is not reset; the count gates it out of visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry, forced to zero when empty so stale storage never leaks.
  assign w_head = out_valid ? r_mem[r_rd] : '0;

  assign wb_lo  = w_head.lo;
  assign wb_hi  = w_head.hi;
  assign wb_two = w_head.two;
  assign flag_z = w_head.z;
  assign flag_n = w_head.n;
  assign op_out = w_head.op;

`ifdef ALU_RESULT_DECODER_STATS_EN
  logic [3:0][15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_push) begin
      r_cnt[op] <= r_cnt[op] + 16'd1;
    end
  end

  assign cnt_add = r_cnt[0];
  assign cnt_sub = r_cnt[1];
  assign cnt_mul = r_cnt[2];
  assign cnt_div = r_cnt[3];
`endif

endmodule

// File: doc/alu_result_decoder.md
ALU_RESULT_DECODER -- requirements
Module: alu_result_decoder

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  packed arithmetic result present.
REQ-005 in_ready  output  1  block can accept a result.
REQ-006 op  input  2  opcode of result: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 result  input  16  signed packed result: {8'b0,sum}, {8'b0,diff}, 16-bit product, or {quotient,remainder}.
REQ-008 out_valid  output  1  decoded write-back entry present.
REQ-009 out_ready  input  1  consumer accepts entry.
REQ-010 wb_lo  output  8  low destination byte.
REQ-011 wb_hi  output  8  high destination byte.
REQ-012 wb_two  output  1  write both bytes (mul, div); else wb_lo only.
REQ-013 flag_z  output  1  zero flag.
REQ-014 flag_n  output  1  negative flag.
REQ-015 op_out  output  2  opcode carried with entry.

Function
REQ-016 Input transfer on rising edge with in_valid && in_ready; output transfer with out_valid && out_ready.
REQ-017 Decode at push: add/sub: wb_lo=result[7:0], wb_hi=sign-extension of result[7], wb_two=0, flag_z=(result[7:0]==0), flag_n=result[7].
REQ-018 mul: wb_lo=result[7:0], wb_hi=result[15:8], wb_two=1, flag_z=(result==0), flag_n=result[15].
REQ-019 div: wb_lo=quotient=result[15:8], wb_hi=remainder=result[7:0], wb_two=1, flag_z=(quotient==0), flag_n=quotient[7].
REQ-020 Decoded entries SHALL be stored in a DEPTH-entry FIFO with wrapping read/write pointers and a count of width log2(DEPTH)+1.
REQ-021 in_ready SHALL equal (count < DEPTH), registered-path only, no combinational dependence on out_ready or in_valid.
REQ-022 out_valid SHALL equal (count != 0); outputs driven from head entry, stable while out_valid && !out_ready.
REQ-023 Latency: result pushed at edge N into empty FIFO SHALL appear on outputs after edge N, i.e. out_valid in cycle N+1; no bypass.
REQ-024 Full: push blocked even if a pop occurs same cycle; count decrements by one.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-026 Pointers wrap from DEPTH-1 to 0; order strictly FIFO.
REQ-027 Upper result bits for add/sub SHALL be ignored (no check).

Reset
REQ-028 rst_n low SHALL immediately clear pointers and count: in_ready=1, out_valid=0, wb_lo=0, wb_hi=0, wb_two=0, flag_z=0, flag_n=0, op_out=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; no transfer on the edge where rst_n deasserts if it is still low at that edge.
REQ-030 Storage array contents need not be cleared; outputs SHALL be forced to 0 whenever count==0.

Configuration
REQ-031 Macro ALU_RESULT_DECODER_STATS_EN: when defined, add outputs cnt_add, cnt_sub, cnt_mul, cnt_div (16 bits each), incrementing on each input transfer of that op, wrapping at 65535->0, reset to 0.
REQ-032 Without ALU_RESULT_DECODER_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Push op=00 result=16'h00F6, out_ready=1 -> next cycle wb_lo=F6, wb_hi=FF, wb_two=0, flag_n=1, flag_z=0.
REQ-034 Push op=10 result=16'hFF00 (-256) -> wb_lo=00, wb_hi=FF, wb_two=1, flag_z=0, flag_n=1; op=11 result=16'h0000 -> wb_lo=00, wb_hi=00, flag_z=1.
REQ-035 out_ready=0, push 4 entries (DEPTH=4) -> in_ready=0 after 4th; 5th in_valid held, not accepted; raise out_ready -> 4 entries drain in order, then 5th.
REQ-036 count=2, push and pop same cycle for 10 cycles -> count stays 2, pointers wrap, output order matches input order.
REQ-037 Assert rst_n low with 3 entries stored -> out_valid=0, in_ready=1 immediately; after release first push appears after one cycle.
REQ-038 With STATS_EN: 3 add, 2 div pushes -> cnt_add=3, cnt_div=2, cnt_sub=0, cnt_mul=0; 65536 mul pushes -> cnt_mul wraps to 0.
